// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data memory between the pipeline MEM stage and the debug unit
module data_mem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        pipe_M_control,
  input  logic [31:0]       pipe_address,
  input  logic [31:0]       pipe_data_write,
  output logic [31:0]       pipe_data_read,
  output logic              pipe_stall,
  output logic              pipe_addr_fault,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_address,
  input  logic [31:0]       dbg_data_write,
  output logic [31:0]       dbg_data_read,
  output logic              dbg_ack,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_write,
  output logic              mem_write,
  input  logic [31:0]       mem_data_read
);
  typedef enum logic [1:0] {IDLE, DBG, ACK} state_t;
  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        dbg_ack_q, dbg_ack_d;
  logic [31:0] dbg_data_read_q, dbg_data_read_d;
  logic        own_dbg, pipe_acc, fault, go;

  // Ownership decision, starvation counting and the memory/pipeline mux; stall never looks at read data
  always_comb begin
    own_dbg         = state_q == DBG;
    pipe_acc        = |pipe_M_control;
    fault           = pipe_acc && (|pipe_address[31:ADDR_W]);
    go              = (state_q == IDLE) && dbg_req && (!pipe_acc || wait_cnt_q == 8'(MAX_WAIT - 1));
    state_d         = go ? DBG : own_dbg ? ACK : IDLE;
    wait_cnt_d      = go ? 8'd0 : ((state_q == IDLE) && dbg_req && pipe_acc) ? wait_cnt_q + 8'd1 : wait_cnt_q;
    dbg_ack_d       = state_d == ACK;
    dbg_data_read_d = own_dbg ? mem_data_read : dbg_data_read_q;
    mem_address     = own_dbg ? dbg_address : pipe_address[ADDR_W-1:0];
    mem_data_write  = own_dbg ? dbg_data_write : pipe_data_write;
    mem_write       = !reset && (own_dbg ? dbg_we : (pipe_M_control[0] && !fault));
    pipe_stall      = own_dbg && pipe_acc;
    pipe_addr_fault = !reset && !own_dbg && fault;
    pipe_data_read  = mem_data_read;
    dbg_ack         = dbg_ack_q;
    dbg_data_read   = dbg_data_read_q;
  end

  // Arbiter state with registered debug handshake outputs; reset abandons any pending debug access
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      wait_cnt_q      <= '0;
      dbg_ack_q       <= 1'b0;
      dbg_data_read_q <= '0;
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      dbg_ack_q       <= dbg_ack_d;
      dbg_data_read_q <= dbg_data_read_d;
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed checks of the data memory arbiter with behavioural memories
module tb_data_mem_arbiter;
  logic        clock, reset;
  logic [1:0]  pipe_M_control;
  logic [31:0] pipe_address, pipe_data_write;
  logic        dbg_req, dbg_we;
  logic [9:0]  dbg_address;
  logic [31:0] dbg_data_write;
  logic [31:0] pipe_data_read, dbg_data_read, mem_data_write, mem_data_read;
  logic        pipe_stall, pipe_addr_fault, dbg_ack, mem_write;
  logic [9:0]  mem_address;
  logic [31:0] pipe_data_read1, dbg_data_read1, mem_data_write1, mem_data_read1;
  logic        pipe_stall1, pipe_addr_fault1, dbg_ack1, mem_write1;
  logic [9:0]  mem_address1;
  logic [31:0] mem [1024];
  logic [31:0] mem1 [1024];
  int tests = 0;
  int fails = 0;
  int acks, first_ack;

  data_mem_arbiter #(.ADDR_W(10), .MAX_WAIT(8)) u0 (
    .clock(clock), .reset(reset), .pipe_M_control(pipe_M_control), .pipe_address(pipe_address),
    .pipe_data_write(pipe_data_write), .pipe_data_read(pipe_data_read), .pipe_stall(pipe_stall),
    .pipe_addr_fault(pipe_addr_fault), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_address(dbg_address),
    .dbg_data_write(dbg_data_write), .dbg_data_read(dbg_data_read), .dbg_ack(dbg_ack),
    .mem_address(mem_address), .mem_data_write(mem_data_write), .mem_write(mem_write),
    .mem_data_read(mem_data_read));

  data_mem_arbiter #(.ADDR_W(10), .MAX_WAIT(1)) u1 (
    .clock(clock), .reset(reset), .pipe_M_control(pipe_M_control), .pipe_address(pipe_address),
    .pipe_data_write(pipe_data_write), .pipe_data_read(pipe_data_read1), .pipe_stall(pipe_stall1),
    .pipe_addr_fault(pipe_addr_fault1), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_address(dbg_address),
    .dbg_data_write(dbg_data_write), .dbg_data_read(dbg_data_read1), .dbg_ack(dbg_ack1),
    .mem_address(mem_address1), .mem_data_write(mem_data_write1), .mem_write(mem_write1),
    .mem_data_read(mem_data_read1));

  assign mem_data_read  = mem[mem_address];
  assign mem_data_read1 = mem1[mem_address1];

  always @(posedge clock) if (mem_write) mem[mem_address] <= mem_data_write;
  always @(posedge clock) if (mem_write1) mem1[mem_address1] <= mem_data_write1;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; pipe_M_control = 2'b01; pipe_address = 32'h0000_1004; pipe_data_write = 32'h1;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_address = 10'd0; dbg_data_write = 32'h0;
    #2;
    chk("rst_stall", {31'd0, pipe_stall}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_fault", {31'd0, pipe_addr_fault}, 32'd0);
    chk("rst_ack", {31'd0, dbg_ack}, 32'd0);
    chk("rst_dbg_data", dbg_data_read, 32'd0);
    tick();
    reset = 1'b0;
    pipe_address = 32'h10; pipe_data_write = 32'hDEADBEEF;
    #1;
    chk("st_mem_write", {31'd0, mem_write}, 32'd1);
    chk("st_mem_addr", {22'd0, mem_address}, 32'h10);
    chk("st_stall", {31'd0, pipe_stall}, 32'd0);
    tick();
    pipe_M_control = 2'b10;
    #1;
    chk("ld_mem_write", {31'd0, mem_write}, 32'd0);
    chk("ld_data", pipe_data_read, 32'hDEADBEEF);
    chk("ld_stall", {31'd0, pipe_stall}, 32'd0);
    tick();
    pipe_M_control = 2'b01; pipe_address = 32'h5; pipe_data_write = 32'h12345678;
    tick();
    pipe_address = 32'h4; pipe_data_write = 32'h44444444;
    tick();
    pipe_M_control = 2'b00; dbg_req = 1'b1; dbg_we = 1'b0; dbg_address = 10'd5;
    #1;
    chk("dr_req_stall", {31'd0, pipe_stall}, 32'd0);
    chk("dr_req_mem_write", {31'd0, mem_write}, 32'd0);
    tick();
    chk("dr_dbg_addr", {22'd0, mem_address}, 32'd5);
    chk("dr_dbg_stall", {31'd0, pipe_stall}, 32'd0);
    chk("dr_dbg_noack", {31'd0, dbg_ack}, 32'd0);
    tick();
    chk("dr_ack", {31'd0, dbg_ack}, 32'd1);
    chk("dr_data", dbg_data_read, 32'h12345678);
    dbg_req = 1'b0;
    tick();
    chk("dr_ack_drop", {31'd0, dbg_ack}, 32'd0);
    pipe_M_control = 2'b10; pipe_address = 32'h7;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_address = 10'd7; dbg_data_write = 32'hA5A5A5A5;
    for (int c = 0; c <= 10; c++) begin
      #1;
      chk($sformatf("col_stall_c%0d", c), {31'd0, pipe_stall}, {31'd0, c == 8});
      chk($sformatf("col_ack_c%0d", c), {31'd0, dbg_ack}, {31'd0, c == 9});
      if (c == 8) chk("col_dbg_write", {31'd0, mem_write}, 32'd1);
      if (c == 9) dbg_req = 1'b0;
      tick();
    end
    #1;
    chk("col_reload", pipe_data_read, 32'hA5A5A5A5);
    pipe_M_control = 2'b01; pipe_address = 32'h0000_1004; pipe_data_write = 32'hFFFFFFFF;
    #1;
    chk("flt_pulse", {31'd0, pipe_addr_fault}, 32'd1);
    chk("flt_mem_write", {31'd0, mem_write}, 32'd0);
    tick();
    pipe_M_control = 2'b10;
    #1;
    chk("flt_alias_read", pipe_data_read, 32'h44444444);
    chk("flt_read_pulse", {31'd0, pipe_addr_fault}, 32'd1);
    tick();
    pipe_address = 32'h4;
    #1;
    chk("flt_clear", {31'd0, pipe_addr_fault}, 32'd0);
    chk("flt_mem4", pipe_data_read, 32'h44444444);
    tick();
    pipe_address = 32'h0; dbg_req = 1'b1; dbg_we = 1'b0; dbg_address = 10'd5;
    acks = 0; first_ack = -1;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (dbg_ack1) begin
        acks++;
        if (first_ack < 0) first_ack = c;
      end
      tick();
    end
    chk("stv_acks", acks, 32'd10);
    chk("stv_first_lat", first_ack, 32'd2);
    dbg_req = 1'b0; pipe_M_control = 2'b00;
    tick(); tick(); tick();
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_address = 10'd5;
    tick();
    pipe_M_control = 2'b10; pipe_address = 32'h5;
    #1;
    chk("rd_pre_stall", {31'd0, pipe_stall}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rd_stall", {31'd0, pipe_stall}, 32'd0);
    chk("rd_ack", {31'd0, dbg_ack}, 32'd0);
    chk("rd_data", dbg_data_read, 32'd0);
    chk("rd_mem_write", {31'd0, mem_write}, 32'd0);
    dbg_req = 1'b0;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("rd_post_ack_c%0d", c), {31'd0, dbg_ack}, 32'd0);
      chk($sformatf("rd_post_stall_c%0d", c), {31'd0, pipe_stall}, 32'd0);
      tick();
    end
    chk("rd_post_load", pipe_data_read, 32'h12345678);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port 1024x32 data memory between two requesters: the pipeline MEM stage and the debug unit (UART load/dump).
- The pipeline owns the memory by default. A debug access takes exactly one memory cycle, and the pipeline is stalled during that cycle if it is also requesting.
- A starvation counter guarantees debug progress while the pipeline accesses memory back to back.
- Sits between the MEM stage and the memory_data instance.

Parameters:
- ADDR_W, 10, memory word-address width; memory depth is 2^ADDR_W.
- MAX_WAIT, 8, maximum number of cycles a pending debug request may be blocked by pipeline accesses before the pipeline is forcibly stalled; range 1..255.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pipe_M_control  in  2  bit0 = mem_write, bit1 = mem_read. 2'b00 means no pipeline access.
- pipe_address  in  32  ALU_out from the MEM stage.
- pipe_data_write  in  32  store data from the pipeline.
- pipe_data_read  out  32  load data returned to the pipeline.
- pipe_stall  out  1  freezes the pipeline for the current cycle.
- pipe_addr_fault  out  1  one-cycle pulse: pipeline access with pipe_address[31:ADDR_W] != 0.
- dbg_req  in  1  debug access request; held high until dbg_ack.
- dbg_we  in  1  1 = write, 0 = read. Sampled while dbg_req is high.
- dbg_address  in  ADDR_W  debug word address.
- dbg_data_write  in  32  debug write data.
- dbg_data_read  out  32  registered debug read data, valid while dbg_ack is high.
- dbg_ack  out  1  one-cycle completion pulse.
- mem_address  out  ADDR_W  to memory_data.
- mem_data_write  out  32  to memory_data.
- mem_write  out  1  to memory_data; the write commits at the rising edge.
- mem_data_read  in  32  from memory_data; combinational read of mem_address.

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is asynchronous and active-high.
  - Reset values: state = IDLE, dbg_ack = 0, dbg_data_read = 0, wait_cnt = 0.
  - While reset is asserted, pipe_stall = 0, mem_write = 0 and pipe_addr_fault = 0.
- States: IDLE, DBG, ACK. State is registered; all mux and stall logic is combinational from state and inputs.
- IDLE (pipeline owns the memory):
  - mem_address = pipe_address[ADDR_W-1:0] and mem_data_write = pipe_data_write.
  - mem_write = pipe_M_control[0] AND NOT fault.
  - pipe_data_read = mem_data_read, so the pipeline sees zero added latency. pipe_stall = 0.
- Fault:
  - fault = (pipe_M_control != 0) AND (pipe_address[31:ADDR_W] != 0).
  - On fault the write is suppressed and pipe_addr_fault pulses for that cycle. Reads still return the aliased word.
  - In the DBG state pipe_addr_fault is forced to 0 (the pipeline access is not executed).
- Leaving IDLE:
  - Move to DBG when dbg_req = 1 AND (pipe_M_control == 0 OR wait_cnt == MAX_WAIT-1).
  - wait_cnt increments each IDLE cycle in which dbg_req = 1 and the pipeline is accessing. It clears on entry to DBG.
- DBG (debug owns the memory for exactly one cycle):
  - mem_address = dbg_address, mem_data_write = dbg_data_write, mem_write = dbg_we.
  - pipe_stall = (pipe_M_control != 0). The pipeline holds its inputs and repeats the access in the next cycle.
  - At the clock edge, dbg_data_read <= mem_data_read (read-before-write value if dbg_we = 1). Next state is ACK.
- ACK:
  - dbg_ack = 1 for this cycle only. The pipeline owns the memory exactly as in IDLE, with no stall.
  - dbg_req is ignored in this cycle. The requester must drop dbg_req here or present its next request. Next state is IDLE.
- Throughput limits:
  - Maximum debug throughput is one access per 3 cycles.
  - Worst-case debug latency from dbg_req to dbg_ack is MAX_WAIT + 2 cycles.
- Simultaneous events:
  - dbg_req arriving while the pipeline is idle goes to DBG on the next edge; no wait is needed.
  - A pipeline request arriving during DBG is stalled, never dropped.
- Reset mid-DBG: any write already committed at a past edge stays in memory. The pending debug access is abandoned with no ack.
- Stall scope: pipe_stall depends only on state and pipe_M_control. It must never depend on mem_data_read (no combinational loop).

Test Plan:
- Pipeline-only traffic: store 0xDEADBEEF to address 0x00000010, then load the same address → mem_write pulses once; the load returns 0xDEADBEEF in the same cycle; pipe_stall stays 0 throughout.
- Debug read while the pipeline is idle: mem[5] = 0x12345678, dbg_req with dbg_we = 0 and dbg_address = 5 → DBG on the next edge, dbg_ack 2 cycles after the request, dbg_data_read = 0x12345678; pipe_stall never asserted.
- Debug write colliding with a pipeline load to 7: dbg_we = 1, dbg_address = 7, data 0xA5A5A5A5, pipeline loading 7 continuously, MAX_WAIT = 8 → pipe_stall asserted in exactly 1 cycle, at cycle 8 after dbg_req; dbg_ack follows 1 cycle later; the pipeline's next load of 7 returns 0xA5A5A5A5.
- Starvation bound: MAX_WAIT = 1 with pipeline accesses every cycle → each debug request is acked within 3 cycles; back-to-back requests over 30 cycles yield 10 acks.
- Address fault: pipeline store to 0x00001004 → pipe_addr_fault = 1 for one cycle, mem_write = 0, mem[4] unchanged.
- Asynchronous reset asserted during DBG → state returns to IDLE immediately; dbg_ack and dbg_data_read read 0; no ack after reset release; the next pipeline access proceeds unstalled.
